// File: rtl/didactic_apb_initiator.sv
// APB3 initiator: turns a valid/ready request into one APB transfer and returns
// a registered response, aborting with a timeout if pready never arrives.
module didactic_apb_initiator #(
    parameter int unsigned ApbAddrWidth  = 12,
    parameter int unsigned ApbDataWidth  = 32,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ApbAddrWidth-1:0] req_addr_i,
    input  logic [ApbDataWidth-1:0] req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [ApbDataWidth-1:0] rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [ApbAddrWidth-1:0] paddr_o,
    output logic [ApbDataWidth-1:0] pwdata_o,
    input  logic [ApbDataWidth-1:0] prdata_i,
    input  logic                    pready_i,
    input  logic                    pslverr_i
);

    localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ApbAddrWidth-1:0] paddr_q, paddr_d;
    logic [ApbDataWidth-1:0] pwdata_q, pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [ApbDataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    timeout_hit;

    // cnt_q counts ACCESS cycles already completed, so the current one is cnt_q+1.
    assign timeout_hit = (TimeoutCycles != 0) && ((32'(cnt_q) + 32'd1) >= TimeoutCycles);

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    pwrite_d  = req_write_i;
                    paddr_d   = req_addr_i;
                    pwdata_d  = req_wdata_i;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (cnt_q != {CntW{1'b1}}) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                if (pready_i) begin
                    rsp_rdata_d   = (pwrite_q || pslverr_i) ? '0 : prdata_i;
                    rsp_err_d     = pslverr_i;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else if (timeout_hit) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign req_ready_o   = rst_ni && (state_q == IDLE);
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_didactic_apb_initiator.sv
// Bench for didactic_apb_initiator: table vectors, random transfers against a
// transaction-level model, plus reset-mid-transfer sequence.
module tb_didactic_apb_initiator;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o, req_write_i;
    logic [11:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o, rsp_timeout_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [11:0] paddr_o;
    logic [31:0] pwdata_o, prdata_i;
    logic        pready_i, pslverr_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    didactic_apb_initiator #(
        .ApbAddrWidth (12),
        .ApbDataWidth (32),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i),
        .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] prd;
        int          waits;
        bit          slverr;
        int          hold;
        logic [31:0] exp_rd;
        bit          exp_err;
        bit          exp_tmo;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: waits = ACCESS cycles with pready low before it rises.
    function automatic void model(input bit wr, input logic [31:0] prd, input int waits,
                                  input bit slverr, output logic [31:0] rd, output bit err,
                                  output bit tmo, output int lat);
        if (waits >= TO) begin
            tmo = 1'b1; err = 1'b1; rd = '0; lat = 2 + TO;
        end else begin
            tmo = 1'b0; err = slverr; rd = (wr || slverr) ? 32'h0 : prd; lat = 3 + waits;
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready_o), 64'd0);
        check({tag, "_psel"}, 64'(psel_o), 64'd0);
        check({tag, "_penable"}, 64'(penable_o), 64'd0);
        check({tag, "_pwrite"}, 64'(pwrite_o), 64'd0);
        check({tag, "_paddr"}, 64'(paddr_o), 64'd0);
        check({tag, "_pwdata"}, 64'(pwdata_o), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata_o), 64'd0);
        check({tag, "_rsp_err"}, 64'(rsp_err_o), 64'd0);
        check({tag, "_rsp_tmo"}, 64'(rsp_timeout_o), 64'd0);
    endtask

    // Entered and left at a negedge with the DUT in IDLE.
    task automatic do_xfer(input vec_t v);
        int  cyc;
        int  acc;
        bit  done;
        logic [31:0] held_rd;
        check("idle_req_ready", 64'(req_ready_o), 64'd1);
        req_valid_i = 1'b1;
        req_write_i = v.wr;
        req_addr_i  = v.addr;
        req_wdata_i = v.wdata;
        rsp_ready_i = 1'b0;
        @(posedge clk_i);
        cyc  = 0;
        acc  = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
            // Garbage on request port while busy must be ignored.
            req_addr_i  = 12'($urandom);
            req_wdata_i = $urandom;
            req_write_i = 1'($urandom);
            if (rsp_valid_o) begin
                check("rsp_latency", 64'(cyc), 64'(v.exp_lat));
                check("access_cycles", 64'(acc), 64'(v.exp_lat - 2));
                check("rsp_rdata", 64'(rsp_rdata_o), 64'(v.exp_rd));
                check("rsp_err", 64'(rsp_err_o), 64'(v.exp_err));
                check("rsp_tmo", 64'(rsp_timeout_o), 64'(v.exp_tmo));
                check("resp_psel", 64'({psel_o, penable_o}), 64'd0);
                check("resp_paddr_kept", 64'(paddr_o), 64'(v.addr));
                held_rd = rsp_rdata_o;
                for (int h = 0; h < v.hold; h++) begin
                    pready_i = 1'($urandom);
                    @(negedge clk_i);
                    check("bp_valid", 64'(rsp_valid_o), 64'd1);
                    check("bp_rdata", 64'(rsp_rdata_o), 64'(held_rd));
                    check("bp_err", 64'({rsp_err_o, rsp_timeout_o}), 64'({v.exp_err, v.exp_tmo}));
                    check("bp_req_ready", 64'(req_ready_o), 64'd0);
                    check("bp_no_apb", 64'(psel_o), 64'd0);
                end
                rsp_ready_i = 1'b1;
                req_valid_i = 1'b0;
                @(negedge clk_i);
                rsp_ready_i = 1'b0;
                check("post_rsp_valid", 64'(rsp_valid_o), 64'd0);
                check("post_req_ready", 64'(req_ready_o), 64'd1);
                check("post_psel", 64'(psel_o), 64'd0);
                done = 1'b1;
            end else if (psel_o) begin
                check("apb_paddr", 64'(paddr_o), 64'(v.addr));
                check("apb_pwrite", 64'(pwrite_o), 64'(v.wr));
                check("apb_pwdata", 64'(pwdata_o), 64'(v.wdata));
                if (!penable_o) begin
                    check("setup_cycle", 64'(cyc), 64'd1);
                    pready_i  = 1'($urandom);
                    pslverr_i = 1'($urandom);
                    prdata_i  = $urandom;
                end else begin
                    check("access_cycle", 64'(cyc), 64'(acc + 2));
                    pready_i  = (acc == v.waits);
                    pslverr_i = pready_i ? v.slverr : 1'($urandom);
                    prdata_i  = pready_i ? v.prd : $urandom;
                    acc++;
                end
            end else begin
                check("unexpected_idle", 64'(cyc), 64'(v.exp_lat));
                done = 1'b1;
            end
        end
        if (!done) check("xfer_budget", 64'(cyc), 64'(v.exp_lat));
        pready_i = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        vec_t        rv;
        logic [31:0] m_rd;
        bit          m_err, m_tmo;
        int          m_lat;

        rst_ni = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
        req_wdata_i = '0; rsp_ready_i = 1'b0; prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;

        //            wr addr    wdata         prd           waits slv hold exp_rd        err tmo lat
        vecs[0] = '{1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 0,   1'b0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 3};
        vecs[1] = '{1'b1, 12'h004, 32'h12345678, 32'hFFFF0000, 3,   1'b0, 0, 32'h0,        1'b0, 1'b0, 6};
        vecs[2] = '{1'b0, 12'h020, 32'h0,        32'hCAFEF00D, 0,   1'b1, 0, 32'h0,        1'b1, 1'b0, 3};
        vecs[3] = '{1'b0, 12'h030, 32'h0,        32'h11111111, 255, 1'b0, 0, 32'h0,        1'b1, 1'b1, 6};
        vecs[4] = '{1'b0, 12'h034, 32'h0,        32'h0BADF00D, 3,   1'b0, 0, 32'h0BADF00D, 1'b0, 1'b0, 6};
        vecs[5] = '{1'b0, 12'h040, 32'h0,        32'h5A5A5A5A, 1,   1'b0, 5, 32'h5A5A5A5A, 1'b0, 1'b0, 4};
        vecs[6] = '{1'b1, 12'hFFC, 32'hA5A5A5A5, 32'h77777777, 2,   1'b1, 1, 32'h0,        1'b1, 1'b0, 5};
        vecs[7] = '{1'b0, 12'h044, 32'h0,        32'h22222222, 4,   1'b0, 2, 32'h0,        1'b1, 1'b1, 6};

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("in_reset");
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("reset_release_ready", 64'(req_ready_o), 64'd1);
        check("reset_release_valid", 64'(rsp_valid_o), 64'd0);

        for (int i = 0; i < 8; i++) do_xfer(vecs[i]);

        // Reset during ACCESS, with a pready that must not produce a response.
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 12'h0AB; req_wdata_i = 32'h13579BDF;
        @(negedge clk_i);
        check("rst_seq_setup", 64'({psel_o, penable_o}), 64'b10);
        pready_i = 1'b0;
        @(negedge clk_i);
        check("rst_seq_access", 64'({psel_o, penable_o}), 64'b11);
        rst_ni = 1'b0; pready_i = 1'b1; pslverr_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("mid_reset");
        pready_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1; req_valid_i = 1'b0;
        @(negedge clk_i);
        check("after_rst_ready", 64'(req_ready_o), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("after_rst_no_rsp", 64'({rsp_valid_o, psel_o}), 64'd0);
        end
        rv = '{1'b0, 12'h010, 32'h0, 32'h600DCAFE, 0, 1'b0, 0, 32'h600DCAFE, 1'b0, 1'b0, 3};
        do_xfer(rv);

        // Random transfers checked against the transaction model.
        for (int n = 0; n < 40; n++) begin
            rv.wr     = 1'($urandom);
            rv.addr   = 12'($urandom);
            rv.wdata  = $urandom;
            rv.prd    = $urandom;
            rv.waits  = int'($urandom_range(0, 6));
            rv.slverr = ($urandom_range(0, 3) == 0);
            rv.hold   = int'($urandom_range(0, 2));
            model(rv.wr, rv.prd, rv.waits, rv.slverr, m_rd, m_err, m_tmo, m_lat);
            rv.exp_rd = m_rd; rv.exp_err = m_err; rv.exp_tmo = m_tmo; rv.exp_lat = m_lat;
            do_xfer(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
